// File: rtl/seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display: blank gap, then drive, per digit.
// Optional feature macro LEADING_ZERO_BLANK_EN keeps anodes of leading-zero digits (k>0) dark.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_CYC  = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [4*NUM_DIGITS-1:0] i_digits_in,
    input  logic                    i_load,
    output logic                    o_load_ack,
    output logic [3:0]              o_disp_val,
    output logic [NUM_DIGITS-1:0]   o_an_n,
    output logic                    o_frame_tick
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL_CYC - 1);
    localparam logic [BW-1:0] LAST_BLANK = BW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_dwell_cnt;
    logic [BW-1:0]         r_blank_cnt;
    logic [VW-1:0]         r_active;
    logic [VW-1:0]         r_pending;
    logic                  r_pend_flag;
    logic                  r_load_ack;
    logic                  r_frame_tick;
    logic [3:0]            r_disp_val;
    logic [NUM_DIGITS-1:0] r_an_n;

    logic [IW-1:0]         w_idx_inc;
    logic [3:0]            w_cur_nib;
    logic [3:0]            w_next_nib;
    logic [NUM_DIGITS-1:0] w_sel_an;
    logic [VW-1:0]         w_commit_val;
    logic                  w_dark;

    assign w_idx_inc    = r_idx + IW'(1);
    assign w_cur_nib    = r_active[{r_idx, 2'b00} +: 4];
    assign w_next_nib   = r_active[{w_idx_inc, 2'b00} +: 4];
    assign w_sel_an     = ~(NUM_DIGITS'(1) << r_idx);
    // A load on the boundary cycle is newer than anything already pending.
    assign w_commit_val = i_load ? i_digits_in : r_pending;

`ifdef LEADING_ZERO_BLANK_EN
    assign w_dark = (r_idx != '0) && ((r_active >> {r_idx, 2'b00}) == '0);
`else
    assign w_dark = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_dwell_cnt  <= '0;
            r_blank_cnt  <= '0;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_flag  <= 1'b0;
            r_load_ack   <= 1'b0;
            r_frame_tick <= 1'b0;
            r_disp_val   <= 4'h0;
            r_an_n       <= '1;
        end else begin
            r_frame_tick <= 1'b0;
            r_load_ack   <= 1'b0;
            if (i_load) begin
                r_pending   <= i_digits_in;
                r_pend_flag <= 1'b1;
            end
            if (!i_enable || (r_state == S_IDLE)) begin
                // Dark display; a scan always (re)starts at the blank gap of digit 0.
                r_state     <= i_enable ? S_BLANK : S_IDLE;
                r_idx       <= '0;
                r_dwell_cnt <= '0;
                r_blank_cnt <= '0;
                r_an_n      <= '1;
                if ((r_state == S_IDLE) && i_load) begin
                    r_active    <= i_digits_in;
                    r_pend_flag <= 1'b0;
                    r_load_ack  <= 1'b1;
                    r_disp_val  <= i_digits_in[3:0];
                end else begin
                    r_disp_val <= r_active[3:0];
                end
            end else begin
                case (r_state)
                    S_BLANK: begin
                        r_disp_val <= w_cur_nib;
                        if (r_blank_cnt == LAST_BLANK) begin
                            r_state     <= S_DRIVE;
                            r_dwell_cnt <= '0;
                            r_an_n      <= w_dark ? '1 : w_sel_an;
                        end else begin
                            r_blank_cnt <= r_blank_cnt + BW'(1);
                        end
                    end
                    S_DRIVE: begin
                        if (r_dwell_cnt == LAST_DWELL) begin
                            r_state     <= S_BLANK;
                            r_blank_cnt <= '0;
                            r_an_n      <= '1;
                            if (r_idx == LAST_IDX) begin
                                // Frame boundary: the only point where a running scan swaps values.
                                r_idx        <= '0;
                                r_frame_tick <= 1'b1;
                                if (i_load || r_pend_flag) begin
                                    r_active    <= w_commit_val;
                                    r_pend_flag <= 1'b0;
                                    r_load_ack  <= 1'b1;
                                    r_disp_val  <= w_commit_val[3:0];
                                end else begin
                                    r_disp_val <= r_active[3:0];
                                end
                            end else begin
                                r_idx      <= w_idx_inc;
                                r_disp_val <= w_next_nib;
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt + DW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_load_ack   = r_load_ack;
    assign o_frame_tick = r_frame_tick;
    assign o_disp_val   = r_disp_val;
    assign o_an_n       = r_an_n;

endmodule
